load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Parametrised load-path unit that replaces the combinational memory-output alignment stage. It accepts a load request from the pipeline and issues one or two word-aligned reads to data memory over a valid/ready interface. It merges and aligns the returned bytes, then sign- or zero-extends the result and returns it with a valid/ready handshake. A word-crossing (misaligned) access is either split into two reads or flagged as an error, selected at compile time.

Parameters:
DATA_W, 32, memory word and result width; legal values 32 or 64; NB = DATA_W/8 bytes per word
ADDR_W, 32, byte address width
MEM_BIG_LANES, 1, 1: byte at address offset k is on mem_rsp_data[DATA_W-1-8k -: 8]; 0: it is on [8k+7 -: 8]

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  load request valid
req_ready  out  1  unit idle, can accept a request
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 double (DATA_W=64 only)
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word-aligned read address (low log2(NB) bits zero)
mem_rsp_valid  in  1  read data valid (one cycle per request, in order)
mem_rsp_data  in  DATA_W  read data
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  DATA_W  aligned, extended load value
resp_err  out  1  request illegal or unsupported (qualified by resp_valid)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE. req_ready=1. mem_req_valid=0. resp_valid=0. resp_data=0. resp_err=0. mem_req_addr=0. All internal captured words=0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, size and unsigned flag.
  - off = addr mod NB. nbytes = 1 << size. cross = (off + nbytes > NB).
  - Illegal request (size=11 with DATA_W=32, or cross without the split feature): go to RESP with resp_err=1 and resp_data=0. No memory access.
  - Legal request: go to REQ0.
- REQ0: mem_req_valid=1, mem_req_addr = addr with low bits cleared. Hold until mem_req_ready, then go to WAIT0.
- WAIT0: on mem_rsp_valid, capture word0. If cross, go to REQ1; else go to RESP.
- REQ1: mem_req_valid=1, mem_req_addr = aligned addr + NB (wraps modulo 2^ADDR_W). On mem_req_ready, go to WAIT1.
- WAIT1: on mem_rsp_valid, capture word1 and go to RESP.
- RESP: resp_valid=1. resp_data/resp_err are registered and stable until resp_ready; then go to IDLE. req_ready=0 in every state except IDLE. There is no same-cycle accept on response retire.
- Byte assembly:
  - Form a 2*NB-byte stream in address order: word0 bytes at offsets 0..NB-1, then word1 bytes. Lane mapping follows MEM_BIG_LANES.
  - Result byte i = stream[off+i] for i < nbytes.
  - Upper bytes are zero if req_unsigned, else replicate bit 7 of the top selected byte.
  - Size = DATA_W width: no extension.
- Latency with zero-wait memory (mem_req_ready=1, rsp one cycle after request):
  - Accept in cycle 0; resp_valid asserts in cycle 3 for a single-read access, cycle 5 for a split access.
- Response arriving in any state other than WAIT0/WAIT1 is ignored.
- rst asserted in any state: next cycle is the reset state. Outstanding memory responses arriving afterwards are dropped (IDLE ignores them).
- At most one outstanding memory request at any time.

Optional Feature:
LOAD_MISALIGN_SPLIT_EN
- Defined: word-crossing accesses are performed as two sequential reads (REQ1/WAIT1 are present) and merged as above.
- Undefined: REQ1/WAIT1 logic is not built. Any cross=1 request goes IDLE→RESP with resp_err=1, resp_data=0, and no mem_req_valid pulse.

Test Plan:
- Test memory setup (DATA_W=32, MEM_BIG_LANES=1): word 0x100 = 0x80818283, word 0x104 = 0x11223344.
- Signed byte at 0x101 → one mem read, addr 0x100; resp_data=0xFFFFFF81, resp_err=0, resp_valid in cycle 3 with zero-wait memory.
- Unsigned half at 0x102 → resp_data=0x00008382. Word at 0x100 → resp_data=0x83828180.
- Word at 0x103 with LOAD_MISALIGN_SPLIT_EN → two mem requests, addr 0x100 then 0x104; resp_data=0x33221183, resp_valid in cycle 5. Without the macro: resp_err=1, resp_data=0, zero mem_req_valid pulses.
- Size=11 with DATA_W=32 → resp_err=1, no memory access. Then hold resp_ready=0 for 5 cycles → resp_valid, resp_data and resp_err stable, req_ready=0 throughout.
- Signed half at 0x100 with mem_req_ready low 3 cycles and response delayed 4 cycles → mem_req_addr stable while stalled; resp_data=0xFFFF8180.
- Assert rst in WAIT0, then pulse mem_rsp_valid one cycle later → resp_valid stays 0, req_ready=1. The next request completes normally.

Source files
------------

// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: pipeline request, memory read port and result port.
// The slave modport is the unit side; master is the surrounding pipeline/memory side.
interface load_align_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, resp_ready,
        output req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, resp_ready,
        input  req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// Load path: issues one or two aligned memory reads, merges, aligns and extends the result.
// LOAD_MISALIGN_SPLIT_EN builds the second-read path; otherwise word-crossing loads error out.
module load_align_unit #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned MEM_BIG_LANES = 1
) (
    input logic              clk,
    input logic              rst,
    load_align_unit_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned SW    = $clog2(2 * NB);

`ifdef LOAD_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

    state_e            state_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [DATA_W-1:0] word0_q;
    logic [DATA_W-1:0] word1_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic              cross_q;
`endif

    logic [OFF_W-1:0] in_off;
    logic [3:0]       in_nbytes;
    logic             in_cross;
    logic             in_illegal;

    always_comb begin
        in_off     = bus.req_addr[OFF_W-1:0];
        in_nbytes  = 4'd1 << bus.req_size;
        in_cross   = (32'(in_off) + 32'(in_nbytes)) > NB;
        in_illegal = ((bus.req_size == 2'b11) && (DATA_W == 32)) || (in_cross && !SplitEn);
    end

    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] aligned;
    logic [7:0]        stream [2*NB];
    logic [3:0]        nbytes;
    logic [SW-1:0]     top_idx;
    logic [SW-1:0]     byte_idx;
    logic              sign_bit;

    // In WAIT1 the second word is still on the bus, so the result is formed in the same cycle.
    always_comb begin
        w0 = (state_q == StWait1) ? word0_q : bus.mem_rsp_data;
        w1 = (state_q == StWait1) ? bus.mem_rsp_data : word1_q;
        for (int k = 0; k < int'(NB); k++) begin
            if (MEM_BIG_LANES != 0) begin
                stream[k]      = w0[DATA_W-1-8*k -: 8];
                stream[NB + k] = w1[DATA_W-1-8*k -: 8];
            end else begin
                stream[k]      = w0[8*k +: 8];
                stream[NB + k] = w1[8*k +: 8];
            end
        end
        nbytes   = 4'd1 << size_q;
        top_idx  = SW'(off_q) + SW'(nbytes - 4'd1);
        sign_bit = !unsigned_q && stream[top_idx][7];
        aligned  = '0;
        byte_idx = '0;
        for (int i = 0; i < int'(NB); i++) begin
            byte_idx = SW'(off_q) + SW'(i);
            aligned[8*i +: 8] = (i < int'(nbytes)) ? stream[byte_idx] : {8{sign_bit}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            off_q             <= '0;
            size_q            <= '0;
            unsigned_q        <= 1'b0;
            word0_q           <= '0;
            word1_q           <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            cross_q           <= 1'b0;
`endif
            bus.req_ready     <= 1'b1;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_data     <= '0;
            bus.resp_err      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        off_q         <= in_off;
                        size_q        <= bus.req_size;
                        unsigned_q    <= bus.req_unsigned;
`ifdef LOAD_MISALIGN_SPLIT_EN
                        cross_q       <= in_cross;
`endif
                        bus.req_ready <= 1'b0;
                        if (in_illegal) begin
                            state_q        <= StResp;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_data  <= '0;
                        end else begin
                            state_q           <= StReq0;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                StReq0: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state_q           <= StWait0;
                    end
                end
                StWait0: begin
                    if (bus.mem_rsp_valid) begin
                        word0_q <= bus.mem_rsp_data;
`ifdef LOAD_MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            state_q           <= StReq1;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_addr  <= bus.mem_req_addr + ADDR_W'(NB);
                        end else
`endif
                        begin
                            state_q        <= StResp;
                            bus.resp_valid <= 1'b1;
                            bus.resp_data  <= aligned;
                            bus.resp_err   <= 1'b0;
                        end
                    end
                end
`ifdef LOAD_MISALIGN_SPLIT_EN
                StReq1: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state_q           <= StWait1;
                    end
                end
                StWait1: begin
                    if (bus.mem_rsp_valid) begin
                        word1_q        <= bus.mem_rsp_data;
                        state_q        <= StResp;
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= aligned;
                        bus.resp_err   <= 1'b0;
                    end
                end
`endif
                StResp: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: vector table plus stall, back-pressure and reset sequences.
// Expected values follow the LOAD_MISALIGN_SPLIT_EN setting of the build.
module tb_load_align_unit;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_align_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    load_align_unit #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .MEM_BIG_LANES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: one response per accepted request, rsp_delay extra cycles after zero-wait.
    int          rsp_delay = 0;
    int          req_cnt   = 0;
    int          wcnt      = 0;
    logic        pend      = 1'b0;
    logic        fire;
    logic [31:0] pend_addr = '0;
    logic [31:0] addr_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h80818283;
            32'h104: return 32'h11223344;
            default: return 32'h5A5A5A5A ^ a;
        endcase
    endfunction

    always @(posedge clk) begin
        fire = 1'b0;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            pend      = 1'b1;
            pend_addr = bus.mem_req_addr;
            wcnt      = rsp_delay;
            addr_log.push_back(bus.mem_req_addr);
            req_cnt++;
        end
        if (pend) begin
            if (wcnt == 0) begin
                fire = 1'b1;
                pend = 1'b0;
            end else begin
                wcnt--;
            end
        end
        #1;
        bus.mem_rsp_valid = fire;
        bus.mem_rsp_data  = fire ? mem_word(pend_addr) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nreq;
        string       name;
    } vec_t;

    task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int n0;
        addr_log.delete();
        n0 = req_cnt;
        chk({v.name, ".req_ready"}, 64'(bus.req_ready), 64'(1'b1));
        issue(v.addr, v.size, v.uns);
        wait_resp(lat);
        chk({v.name, ".valid"}, 64'(bus.resp_valid), 64'(1'b1));
        chk({v.name, ".latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, ".data"}, 64'(bus.resp_data), 64'(v.data));
        chk({v.name, ".err"}, 64'(bus.resp_err), 64'(v.err));
        chk({v.name, ".nreq"}, 64'(req_cnt - n0), 64'(v.nreq));
        if (v.nreq > 0 && addr_log.size() > 0)
            chk({v.name, ".addr0"}, 64'(addr_log[0]), 64'({v.addr[31:2], 2'b00}));
        if (v.nreq > 1 && addr_log.size() > 1)
            chk({v.name, ".addr1"}, 64'(addr_log[1]), 64'({v.addr[31:2], 2'b00} + 32'd4));
        @(posedge clk);
        #1;
        chk({v.name, ".retired"}, 64'(bus.resp_valid), 64'(1'b0));
        chk({v.name, ".idle"}, 64'(bus.req_ready), 64'(1'b1));
    endtask

    vec_t vecs[13];

    initial begin
        int lat;
        int n0;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_size      = 2'd0;
        bus.req_unsigned  = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.resp_ready    = 1'b1;

        vecs[0]  = '{32'h101, 2'd0, 1'b0, 32'hFFFFFF81, 1'b0, 3, 1, "sbyte_101"};
        vecs[1]  = '{32'h102, 2'd1, 1'b1, 32'h00008382, 1'b0, 3, 1, "uhalf_102"};
        vecs[2]  = '{32'h100, 2'd2, 1'b0, 32'h83828180, 1'b0, 3, 1, "word_100"};
        vecs[3]  = '{32'h100, 2'd0, 1'b1, 32'h00000080, 1'b0, 3, 1, "ubyte_100"};
        vecs[4]  = '{32'h102, 2'd1, 1'b0, 32'hFFFF8382, 1'b0, 3, 1, "shalf_102"};
        vecs[5]  = '{32'h104, 2'd0, 1'b0, 32'h00000011, 1'b0, 3, 1, "sbyte_104"};
        vecs[6]  = '{32'h106, 2'd1, 1'b0, 32'h00004433, 1'b0, 3, 1, "shalf_106"};
        vecs[7]  = '{32'h104, 2'd2, 1'b1, 32'h44332211, 1'b0, 3, 1, "word_104"};
        vecs[8]  = '{32'h100, 2'd3, 1'b0, 32'h00000000, 1'b1, 1, 0, "dword_illegal"};
        vecs[9]  = '{32'h101, 2'd1, 1'b1, 32'h00008281, 1'b0, 3, 1, "uhalf_101"};
        vecs[10] = '{32'h103, 2'd0, 1'b1, 32'h00000083, 1'b0, 3, 1, "ubyte_103"};
`ifdef LOAD_MISALIGN_SPLIT_EN
        vecs[11] = '{32'h103, 2'd2, 1'b0, 32'h33221183, 1'b0, 5, 2, "word_103_split"};
        vecs[12] = '{32'h103, 2'd1, 1'b0, 32'h00001183, 1'b0, 5, 2, "shalf_103_split"};
`else
        vecs[11] = '{32'h103, 2'd2, 1'b0, 32'h00000000, 1'b1, 1, 0, "word_103_err"};
        vecs[12] = '{32'h103, 2'd1, 1'b0, 32'h00000000, 1'b1, 1, 0, "shalf_103_err"};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 64'(bus.req_ready), 64'(1'b1));
        chk("rst.mem_req_valid", 64'(bus.mem_req_valid), 64'(1'b0));
        chk("rst.mem_req_addr", 64'(bus.mem_req_addr), 64'(32'h0));
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'(1'b0));
        chk("rst.resp_data", 64'(bus.resp_data), 64'(32'h0));
        chk("rst.resp_err", 64'(bus.resp_err), 64'(1'b0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Illegal request with the consumer back-pressuring for five cycles.
        bus.resp_ready = 1'b0;
        n0 = req_cnt;
        issue(32'h100, 2'd3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("hold.valid", 64'(bus.resp_valid), 64'(1'b1));
            chk("hold.data", 64'(bus.resp_data), 64'(32'h0));
            chk("hold.err", 64'(bus.resp_err), 64'(1'b1));
            chk("hold.req_ready", 64'(bus.req_ready), 64'(1'b0));
            @(posedge clk);
            #1;
        end
        chk("hold.nreq", 64'(req_cnt - n0), 64'(0));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold.retired", 64'(bus.resp_valid), 64'(1'b0));

        // Request stalled three cycles, then the response comes four cycles late.
        bus.mem_req_ready = 1'b0;
        rsp_delay         = 4;
        n0                = req_cnt;
        issue(32'h100, 2'd1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall.mem_req_valid", 64'(bus.mem_req_valid), 64'(1'b1));
            chk("stall.mem_req_addr", 64'(bus.mem_req_addr), 64'(32'h100));
            @(posedge clk);
            #1;
        end
        bus.mem_req_ready = 1'b1;
        wait_resp(lat);
        lat = lat + 3;
        chk("stall.valid", 64'(bus.resp_valid), 64'(1'b1));
        chk("stall.latency", 64'(lat), 64'(10));
        chk("stall.data", 64'(bus.resp_data), 64'(32'hFFFF8180));
        chk("stall.err", 64'(bus.resp_err), 64'(1'b0));
        chk("stall.nreq", 64'(req_cnt - n0), 64'(1));
        rsp_delay = 0;
        @(posedge clk);
        #1;

        // Reset while waiting for data; the late response must be dropped.
        rsp_delay = 1;
        n0        = req_cnt;
        issue(32'h100, 2'd2, 1'b0);
        @(posedge clk);
        #1;
        chk("rstw.in_wait", 64'(bus.mem_req_valid), 64'(1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rstw.resp_valid", 64'(bus.resp_valid), 64'(1'b0));
            chk("rstw.req_ready", 64'(bus.req_ready), 64'(1'b1));
            chk("rstw.mem_req_valid", 64'(bus.mem_req_valid), 64'(1'b0));
            @(posedge clk);
            #1;
        end
        chk("rstw.nreq", 64'(req_cnt - n0), 64'(1));
        rsp_delay = 0;
        run_vec(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
